// File: rtl/blimp_mem_pkg.sv
// Shared types and constants for the BlimpV6 memory responder.
// The optional byte-strobe feature is BLIMP_MEM_RESPONDER_BYTE_STRB_EN.
package blimp_mem_pkg;

  typedef enum logic {
    MEM_READ  = 1'b0,
    MEM_WRITE = 1'b1
  } mem_op_e;

  localparam int unsigned MEM_OPAQ_BITS  = 8;
  localparam int unsigned MEM_ADDR_BITS  = 32;
  localparam int unsigned MEM_DATA_BITS  = 32;
  localparam int unsigned MEM_NUM_WORDS  = 256;
  localparam int unsigned MEM_DELAY_BITS = 4;

  // Responder FSM states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  function automatic logic [MEM_DELAY_BITS-1:0] delay_load(input int unsigned delay);
    return (delay == 0) ? '0 : MEM_DELAY_BITS'(delay - 1);
  endfunction

endpackage

// File: rtl/blimp_mem_responder_array.sv
// Word array with one synchronous byte-strobed write port and one registered read port.
// Response data is cleared on write acceptance so write responses carry zero.
module blimp_mem_responder_array
  import blimp_mem_pkg::*;
#(
  parameter int unsigned p_data_bits = MEM_DATA_BITS,
  parameter int unsigned p_num_words = MEM_NUM_WORDS
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_acc,
  input  logic                           i_we,
  input  logic [$clog2(p_num_words)-1:0] i_idx,
  input  logic [p_data_bits-1:0]         i_wdata,
  input  logic [p_data_bits/8-1:0]       i_strb,
  output logic [p_data_bits-1:0]         o_rdata
);

  localparam int unsigned STRB_W = p_data_bits / 8;

  logic [p_data_bits-1:0] r_mem [p_num_words];
  logic [p_data_bits-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_acc && i_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (i_strb[b]) r_mem[i_idx][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (i_acc) begin
      r_rdata <= i_we ? '0 : r_mem[i_idx];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/blimp_mem_responder.sv
// BlimpV6 memory responder: val/rdy request in, tagged response out after p_resp_delay cycles.
// Define BLIMP_MEM_RESPONDER_BYTE_STRB_EN to add the req_strb byte-lane write strobe.
module blimp_mem_responder
  import blimp_mem_pkg::*;
#(
  parameter int unsigned p_opaq_bits  = MEM_OPAQ_BITS,
  parameter int unsigned p_addr_bits  = MEM_ADDR_BITS,
  parameter int unsigned p_data_bits  = MEM_DATA_BITS,
  parameter int unsigned p_num_words  = MEM_NUM_WORDS,
  parameter int unsigned p_resp_delay = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_val,
  output logic                   req_rdy,
  input  logic                   req_op,
  input  logic [p_opaq_bits-1:0] req_opaque,
  input  logic [p_addr_bits-1:0] req_addr,
  input  logic [p_data_bits-1:0] req_data,
`ifdef BLIMP_MEM_RESPONDER_BYTE_STRB_EN
  input  logic [p_data_bits/8-1:0] req_strb,
`endif
  output logic                   resp_val,
  input  logic                   resp_rdy,
  output logic                   resp_op,
  output logic [p_opaq_bits-1:0] resp_opaque,
  output logic [p_data_bits-1:0] resp_data
);

  localparam int unsigned IDX_W = $clog2(p_num_words);
  localparam logic [MEM_DELAY_BITS-1:0] DELAY_LOAD = delay_load(p_resp_delay);

  logic [1:0]                r_state, w_state_next;
  logic [MEM_DELAY_BITS-1:0] r_cnt, w_cnt_next;
  logic                      r_resp_op;
  logic [p_opaq_bits-1:0]    r_resp_opaque;
  logic                      w_accept;
  logic [p_data_bits/8-1:0]  w_strb;
  logic [IDX_W-1:0]          w_idx;
  logic                      w_unused_addr;

`ifdef BLIMP_MEM_RESPONDER_BYTE_STRB_EN
  assign w_strb = req_strb;
`else
  assign w_strb = '1;
`endif

  // Byte offset and bits above the array depth are dropped, so addresses wrap.
  assign w_idx         = req_addr[IDX_W+1:2];
  assign w_unused_addr = ^req_addr;

  // Ready is combinational on resp_rdy in RESP so back-to-back transactions need no bubble.
  assign req_rdy  = rst_n && ((r_state == ST_IDLE) || ((r_state == ST_RESP) && resp_rdy));
  assign w_accept = req_val && req_rdy;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      ST_IDLE: w_state_next = ST_IDLE;
      ST_WAIT: begin
        if (r_cnt == '0) w_state_next = ST_RESP;
        else             w_cnt_next   = r_cnt - 1'b1;
      end
      ST_RESP: if (resp_rdy) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
    if (w_accept) begin
      w_state_next = (p_resp_delay != 0) ? ST_WAIT : ST_RESP;
      w_cnt_next   = DELAY_LOAD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_resp_op     <= 1'b0;
      r_resp_opaque <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_resp_op     <= req_op;
        r_resp_opaque <= req_opaque;
      end
    end
  end

  blimp_mem_responder_array #(
    .p_data_bits (p_data_bits),
    .p_num_words (p_num_words)
  ) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_acc   (w_accept),
    .i_we    (req_op == MEM_WRITE),
    .i_idx   (w_idx),
    .i_wdata (req_data),
    .i_strb  (w_strb),
    .o_rdata (resp_data)
  );

  assign resp_val    = (r_state == ST_RESP);
  assign resp_op     = r_resp_op;
  assign resp_opaque = r_resp_opaque;

endmodule

// File: tb/tb_blimp_mem_responder.sv
// Directed bench: instance A has zero response delay, instance B has a delay of 3.
// Byte-strobe steps are included when BLIMP_MEM_RESPONDER_BYTE_STRB_EN is defined.
module tb_blimp_mem_responder;

  logic clk = 1'b0;
  logic rst_n;

  logic        a_req_val, a_req_rdy, a_req_op, a_resp_val, a_resp_rdy, a_resp_op;
  logic [7:0]  a_req_opaque, a_resp_opaque;
  logic [31:0] a_req_addr, a_req_data, a_resp_data;
  logic        b_req_val, b_req_rdy, b_req_op, b_resp_val, b_resp_rdy, b_resp_op;
  logic [7:0]  b_req_opaque, b_resp_opaque;
  logic [31:0] b_req_addr, b_req_data, b_resp_data;
`ifdef BLIMP_MEM_RESPONDER_BYTE_STRB_EN
  logic [3:0]  a_req_strb, b_req_strb;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  blimp_mem_responder #(.p_resp_delay(0)) u_a (
    .clk(clk), .rst_n(rst_n),
    .req_val(a_req_val), .req_rdy(a_req_rdy), .req_op(a_req_op),
    .req_opaque(a_req_opaque), .req_addr(a_req_addr), .req_data(a_req_data),
`ifdef BLIMP_MEM_RESPONDER_BYTE_STRB_EN
    .req_strb(a_req_strb),
`endif
    .resp_val(a_resp_val), .resp_rdy(a_resp_rdy), .resp_op(a_resp_op),
    .resp_opaque(a_resp_opaque), .resp_data(a_resp_data)
  );

  blimp_mem_responder #(.p_resp_delay(3)) u_b (
    .clk(clk), .rst_n(rst_n),
    .req_val(b_req_val), .req_rdy(b_req_rdy), .req_op(b_req_op),
    .req_opaque(b_req_opaque), .req_addr(b_req_addr), .req_data(b_req_data),
`ifdef BLIMP_MEM_RESPONDER_BYTE_STRB_EN
    .req_strb(b_req_strb),
`endif
    .resp_val(b_resp_val), .resp_rdy(b_resp_rdy), .resp_op(b_resp_op),
    .resp_opaque(b_resp_opaque), .resp_data(b_resp_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic a_req(input logic op, input logic [7:0] tag, input logic [31:0] addr,
                       input logic [31:0] data);
    a_req_val = 1'b1; a_req_op = op; a_req_opaque = tag; a_req_addr = addr; a_req_data = data;
  endtask

  task automatic b_req(input logic op, input logic [7:0] tag, input logic [31:0] addr,
                       input logic [31:0] data);
    b_req_val = 1'b1; b_req_op = op; b_req_opaque = tag; b_req_addr = addr; b_req_data = data;
  endtask

  task automatic a_resp(input string tag, input logic op, input logic [7:0] otag,
                        input logic [31:0] data);
    chk({tag, "_val"},    32'(a_resp_val),    32'd1);
    chk({tag, "_op"},     32'(a_resp_op),     32'(op));
    chk({tag, "_opaque"}, 32'(a_resp_opaque), 32'(otag));
    chk({tag, "_data"},   a_resp_data,        data);
  endtask

  task automatic b_resp(input string tag, input logic op, input logic [7:0] otag,
                        input logic [31:0] data);
    chk({tag, "_val"},    32'(b_resp_val),    32'd1);
    chk({tag, "_op"},     32'(b_resp_op),     32'(op));
    chk({tag, "_opaque"}, 32'(b_resp_opaque), 32'(otag));
    chk({tag, "_data"},   b_resp_data,        data);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    a_req_val = 0; a_req_op = 0; a_req_opaque = 0; a_req_addr = 0; a_req_data = 0; a_resp_rdy = 1;
    b_req_val = 0; b_req_op = 0; b_req_opaque = 0; b_req_addr = 0; b_req_data = 0; b_resp_rdy = 1;
`ifdef BLIMP_MEM_RESPONDER_BYTE_STRB_EN
    a_req_strb = 4'hF; b_req_strb = 4'hF;
`endif
    tick(); tick();
    chk("rst_a_req_rdy",   32'(a_req_rdy),     32'd0);
    chk("rst_a_resp_val",  32'(a_resp_val),    32'd0);
    chk("rst_a_resp_op",   32'(a_resp_op),     32'd0);
    chk("rst_a_resp_tag",  32'(a_resp_opaque), 32'd0);
    chk("rst_a_resp_data", a_resp_data,        32'd0);
    chk("rst_b_req_rdy",   32'(b_req_rdy),     32'd0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_a_req_rdy", 32'(a_req_rdy), 32'd1);
    chk("post_rst_b_req_rdy", 32'(b_req_rdy), 32'd1);

    // Delay 0: write then back-to-back read of the same word.
    tick();
    a_req(1'b1, 8'd3, 32'h10, 32'hDEADBEEF);
    tick();
    a_resp("d0_wr", 1'b1, 8'd3, 32'h0);
    chk("d0_rdy_in_resp", 32'(a_req_rdy), 32'd1);
    a_req(1'b0, 8'd4, 32'h10, 32'h0);
    tick();
    a_resp("d0_rd", 1'b0, 8'd4, 32'hDEADBEEF);
    a_req_val = 1'b0;
    tick();
    chk("d0_idle_val", 32'(a_resp_val), 32'd0);

    // Address wrap: 0x400 and 0x003 alias word 0.
    a_req(1'b1, 8'd5, 32'h400, 32'h55);
    tick();
    a_resp("wrap_wr", 1'b1, 8'd5, 32'h0);
    a_req(1'b0, 8'd6, 32'h000, 32'h0);
    tick();
    a_resp("wrap_rd0", 1'b0, 8'd6, 32'h55);
    a_req(1'b0, 8'd7, 32'h003, 32'h0);
    tick();
    a_resp("wrap_rd3", 1'b0, 8'd7, 32'h55);
    a_req_val = 1'b0;
    tick();

    // Backpressure: outputs frozen, pending request waits for resp_rdy.
    a_resp_rdy = 1'b0;
    a_req(1'b0, 8'd9, 32'h10, 32'h0);
    tick();
    a_req(1'b0, 8'd10, 32'h400, 32'h0);
    for (int i = 0; i < 5; i++) begin
      a_resp("bp_hold", 1'b0, 8'd9, 32'hDEADBEEF);
      chk("bp_req_rdy", 32'(a_req_rdy), 32'd0);
      tick();
    end
    a_resp_rdy = 1'b1;
    #1;
    chk("bp_release_rdy", 32'(a_req_rdy), 32'd1);
    tick();
    a_resp("bp_next", 1'b0, 8'd10, 32'h55);
    a_req_val = 1'b0;
    tick();
    chk("bp_idle_val", 32'(a_resp_val), 32'd0);

    // Delay 3: three WAIT cycles after acceptance, then RESP.
    b_req(1'b1, 8'd1, 32'h8, 32'hCAFEF00D);
    tick();
    b_req_val = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("d3_wait_val", 32'(b_resp_val), 32'd0);
      chk("d3_wait_rdy", 32'(b_req_rdy),  32'd0);
      tick();
    end
    b_resp("d3_wr", 1'b1, 8'd1, 32'h0);
    chk("d3_resp_rdy", 32'(b_req_rdy), 32'd1);
    b_req(1'b0, 8'd2, 32'h8, 32'h0);
    tick();
    b_req_val = 1'b0;
    chk("d3_rd_wait_val", 32'(b_resp_val), 32'd0);
    tick(); tick(); tick();
    b_resp("d3_rd", 1'b0, 8'd2, 32'hCAFEF00D);
    tick();

    // Reset during WAIT drops the response but keeps the accepted write.
    b_req(1'b1, 8'h21, 32'h20, 32'h1234);
    tick();
    b_req_val = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("mrst_val",  32'(b_resp_val),    32'd0);
    chk("mrst_op",   32'(b_resp_op),     32'd0);
    chk("mrst_tag",  32'(b_resp_opaque), 32'd0);
    chk("mrst_data", b_resp_data,        32'd0);
    chk("mrst_rdy",  32'(b_req_rdy),     32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mrst_no_resp", 32'(b_resp_val), 32'd0);
    end
    b_req(1'b0, 8'h22, 32'h20, 32'h0);
    tick();
    b_req_val = 1'b0;
    tick(); tick(); tick();
    b_resp("mrst_rd", 1'b0, 8'h22, 32'h1234);
    tick();

`ifdef BLIMP_MEM_RESPONDER_BYTE_STRB_EN
    a_req(1'b1, 8'd11, 32'h30, 32'hFFFFFFFF);
    a_req_strb = 4'hF;
    tick();
    a_req(1'b1, 8'd12, 32'h30, 32'h00000000);
    a_req_strb = 4'b0101;
    tick();
    a_req(1'b0, 8'd13, 32'h30, 32'h0);
    a_req_strb = 4'h0;
    tick();
    a_resp("strb_rd", 1'b0, 8'd13, 32'hFF00FF00);
    a_req_val = 1'b0;
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
